// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259A host bus master.
// PIC_HOST_8085_EN selects the 3-pulse 8085 CALL acknowledge.
package pic_host_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_STROBE     = 3'd2;
    localparam logic [2:0] ST_HOLD       = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;
    localparam logic [2:0] ST_ACK_STROBE = 3'd5;
    localparam logic [2:0] ST_ACK_GAP    = 3'd6;

`ifdef PIC_HOST_8085_EN
    localparam logic [1:0] NPULSE = 2'd3;
`else
    localparam logic [1:0] NPULSE = 2'd2;
`endif

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    typedef struct packed {
        logic       write;
        logic       a0;
        logic [7:0] data;
    } cmd_t;

endpackage

// File: rtl/pic_host_sync.sv
// Two-flop synchronizer for the asynchronous PIC INT line.
module pic_host_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pic_host_master.sv
// CPU-side 8259A bus master: register reads/writes and INTA sequencing.
// Define PIC_HOST_8085_EN for the 3-pulse 8085 CALL acknowledge.
module pic_host_master
    import pic_host_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [7:0]  D,
    output logic        A0,
    output logic        CS_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic        INTA_n,
    input  logic        INT,
    input  logic        int_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_a0,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        vec_valid,
    output logic [15:0] vec
);

    localparam int MAXC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    pulse;
    cmd_t          cmd_q;
    logic          int_s;
    logic          bus_act;
    logic          ack_req;
`ifdef PIC_HOST_8085_EN
    logic [7:0]    lo_q;
`endif

    pic_host_sync u_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (INT),
        .sync_out (int_s)
    );

    assign ack_req = int_en && int_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pulse    <= 2'd0;
            cmd_q    <= '0;
            rsp_data <= 8'h00;
            vec      <= 16'h0000;
`ifdef PIC_HOST_8085_EN
            lo_q     <= 8'h00;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    pulse <= 2'd0;
                    // Acknowledge has priority over a pending command
                    if (ack_req) begin
                        state <= ST_ACK_STROBE;
                    end else if (cmd_valid) begin
                        cmd_q <= '{write: cmd_write, a0: cmd_a0, data: cmd_data};
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: state <= ST_STROBE;
                ST_STROBE: begin
                    if (cnt == S_LAST) begin
                        cnt   <= '0;
                        state <= ST_HOLD;
                        if (!cmd_q.write) rsp_data <= D;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: state <= ST_GAP;
                ST_GAP: begin
                    if (cnt == G_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACK_STROBE: begin
                    if (cnt == S_LAST) begin
                        cnt   <= '0;
                        state <= ST_ACK_GAP;
`ifdef PIC_HOST_8085_EN
                        // Pulse 0 carries the CALL opcode and is dropped
                        if (pulse == 2'd1) lo_q <= D;
                        if (pulse == 2'd2) vec  <= {D, lo_q};
`else
                        if (pulse == 2'd1) vec <= {8'h00, D};
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACK_GAP: begin
                    if (cnt == G_LAST) begin
                        cnt <= '0;
                        if (pulse == NPULSE - 2'd1) begin
                            state <= ST_IDLE;
                        end else begin
                            pulse <= pulse + 2'd1;
                            state <= ST_ACK_STROBE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus_act   = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
    assign CS_n      = !bus_act;
    assign A0        = cmd_q.a0;
    assign WR_n      = !((state == ST_STROBE) && cmd_q.write);
    assign RD_n      = !((state == ST_STROBE) && !cmd_q.write);
    assign INTA_n    = (state != ST_ACK_STROBE);
    assign D         = (bus_act && cmd_q.write) ? cmd_q.data : 8'hzz;
    assign rsp_valid = (state == ST_HOLD) && !cmd_q.write;
    assign vec_valid = (state == ST_ACK_GAP) && (pulse == NPULSE - 2'd1) && (cnt == '0);
    assign cmd_ready = (state == ST_IDLE) && !ack_req;

endmodule

// File: tb/tb_pic_host_master.sv
// Directed bench for pic_host_master with a small 8259A bus model.
module tb_pic_host_master;

`ifdef PIC_HOST_8085_EN
    localparam int NP = 3;
    localparam logic [15:0] EXP_VEC = 16'h1020;
`else
    localparam int NP = 2;
    localparam logic [15:0] EXP_VEC = 16'h0048;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    wire  [7:0]  D;
    logic        A0, CS_n, RD_n, WR_n, INTA_n;
    logic        INT, int_en;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_a0;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        vec_valid;
    logic [15:0] vec;

    logic [7:0]  rd_byte;
    logic [7:0]  ack_byte;
    logic        probe;
    logic [7:0]  ack_bytes [0:2];

    // PIC model: answers reads and INTA, probe drives A5 to show DUT release
    assign D = (!RD_n && !CS_n) ? rd_byte :
               (!INTA_n ? ack_byte : (probe ? 8'hA5 : 8'hzz));

    pic_host_master dut (
        .CLK(CLK), .RST(RST), .D(D), .A0(A0), .CS_n(CS_n),
        .RD_n(RD_n), .WR_n(WR_n), .INTA_n(INTA_n), .INT(INT),
        .int_en(int_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vec_valid(vec_valid), .vec(vec)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic       inta_l [0:31];
    logic       cs_l   [0:31];
    logic       wr_l   [0:31];
    logic       rd_l   [0:31];
    logic       a0_l   [0:31];
    logic       rdy_l  [0:31];
    logic       vv_l   [0:31];
    logic       rv_l   [0:31];
    logic [7:0] d_l    [0:31];
    int         cmd_at;
    int         probe_from;
    int         f;
    int         cnt;

    // Cycle i of a run is the low phase before edge i
    task automatic run(input int n);
        logic hs;
        logic prev;
        int   pc;
        prev = 1'b1;
        pc   = 0;
        for (int i = 0; i < n; i++) begin
            probe = (i >= probe_from);
            @(negedge CLK);
            if (!INTA_n && prev) begin
                if (pc < 3) ack_byte = ack_bytes[pc];
                pc++;
                INT = 1'b0;
            end
            prev     = INTA_n;
            inta_l[i] = INTA_n;
            cs_l[i]   = CS_n;
            wr_l[i]   = WR_n;
            rd_l[i]   = RD_n;
            a0_l[i]   = A0;
            rdy_l[i]  = cmd_ready;
            vv_l[i]   = vec_valid;
            rv_l[i]   = rsp_valid;
            d_l[i]    = D;
            hs = cmd_valid && cmd_ready;
            @(posedge CLK);
            #1;
            if (hs) cmd_valid = 1'b0;
            if (i + 1 == cmd_at) cmd_valid = 1'b1;
        end
        probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; INT = 1'b0; int_en = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
        rd_byte = 8'h00; ack_byte = 8'h00; probe = 1'b0;
        cmd_at = -1; probe_from = 99;
`ifdef PIC_HOST_8085_EN
        ack_bytes[0] = 8'hCD; ack_bytes[1] = 8'h20; ack_bytes[2] = 8'h10;
`else
        ack_bytes[0] = 8'hFF; ack_bytes[1] = 8'h48; ack_bytes[2] = 8'h00;
`endif

        #12;
        check("rst_cs",   CS_n, 1);
        check("rst_rdwr", {RD_n, WR_n, INTA_n}, 3'b111);
        check("rst_a0",   A0, 0);
        check("rst_valid", {rsp_valid, vec_valid}, 2'b00);
        check("rst_rdata", rsp_data, 8'h00);
        check("rst_vec",  vec, 16'h0000);
        check("rst_ready", cmd_ready, 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(2);

        // Write A0=0 data 0x13
        cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h13; cmd_valid = 1'b1;
        probe_from = 5;
        run(7);
        probe_from = 99;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("wr_cs%0d", k), cs_l[k], (k <= 4) ? 1'b0 : 1'b1);
            check($sformatf("wr_wr%0d", k), wr_l[k], (k == 2 || k == 3) ? 1'b0 : 1'b1);
            check($sformatf("wr_d%0d", k), d_l[k], (k <= 4) ? 8'h13 : 8'hA5);
        end
        check("wr_rdy5", rdy_l[5], 0);
        check("wr_rdy6", rdy_l[6], 1);
        idle(2);

        // Read A0=1, PIC returns 0x5A
        cmd_write = 1'b0; cmd_a0 = 1'b1; rd_byte = 8'h5A; cmd_valid = 1'b1;
        run(7);
        check("rd_a0", a0_l[1], 1);
        check("rd_strobe", {rd_l[1], rd_l[2], rd_l[3], rd_l[4]}, 4'b1001);
        check("rd_nowr", {wr_l[2], wr_l[3]}, 2'b11);
        check("rd_rv", {rv_l[3], rv_l[4], rv_l[5]}, 3'b010);
        cnt = 0;
        for (int k = 0; k < 7; k++) if (rv_l[k]) cnt++;
        check("rd_rvcnt", 16'(cnt), 1);
        check("rd_data", rsp_data, 8'h5A);
        idle(2);

        // Interrupt acknowledge
        int_en = 1'b1; INT = 1'b1;
        run(NP * 3 + 6);
        f = -1;
        for (int k = 0; k < NP * 3 + 6; k++) if (f < 0 && !inta_l[k]) f = k;
        check("ack_lat", 16'(f), 3);
        for (int j = 0; j < NP * 3; j++)
            check($sformatf("ack_inta%0d", j), inta_l[3 + j], (j % 3 == 2) ? 1'b1 : 1'b0);
        check("ack_end", inta_l[3 + NP * 3], 1);
        cnt = 0;
        for (int k = 0; k < NP * 3 + 6; k++) if (!cs_l[k]) cnt++;
        check("ack_cs", 16'(cnt), 0);
        cnt = 0;
        for (int k = 0; k < NP * 3 + 6; k++) if (vv_l[k]) cnt++;
        check("ack_vvcnt", 16'(cnt), 1);
        check("ack_vvpos", vv_l[3 + NP * 3 - 1], 1);
        check("ack_vec", vec, EXP_VEC);
        check("ack_rdy", rdy_l[3 + NP * 3], 1);
        idle(2);

        // INT and command arrive together: acknowledge first
        INT = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h55;
        cmd_at = 2;
        run(NP * 3 + 10);
        cmd_at = -1;
        check("col_rdy2", rdy_l[2], 0);
        f = -1;
        for (int k = 0; k < NP * 3 + 10; k++) if (f < 0 && !inta_l[k]) f = k;
        check("col_ack", 16'(f), 3);
        f = -1;
        for (int k = 0; k < NP * 3 + 10; k++) if (f < 0 && !cs_l[k]) f = k;
        check("col_cs", 16'(f), 16'(3 + NP * 3 + 1));
        check("col_d", d_l[3 + NP * 3 + 1], 8'h55);
        idle(4);

        // int_en low: INT ignored
        int_en = 1'b0; INT = 1'b1;
        run(8);
        cnt = 0;
        for (int k = 0; k < 8; k++) if (!inta_l[k]) cnt++;
        check("dis_inta", 16'(cnt), 0);
        check("dis_rdy", rdy_l[7], 1);
        INT = 1'b0;
        idle(3);

        // Reset during write strobe
        cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h3C; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        check("rs_wrlow", WR_n, 0);
        probe = 1'b1;
        RST = 1'b1;
        #1;
        check("rs_wr", WR_n, 1);
        check("rs_cs", CS_n, 1);
        check("rs_d", D, 8'hA5);
        #1;
        RST = 1'b0;
        probe = 1'b0;
        run(4);
        check("rs_rdy", rdy_l[0], 1);
        cnt = 0;
        for (int k = 0; k < 4; k++) if (rv_l[k] || !cs_l[k]) cnt++;
        check("rs_quiet", 16'(cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pic_host_master.md
# pic_host_master

CPU-side bus master for the 8259A interrupt controller: drives the PIC's RD_n/WR_n/A0/CS_n/D pins to write ICW/OCW bytes and read status registers on request, and answers INT with the INTA_n pulse train while capturing the interrupt vector the PIC places on D. It sits opposite the PIC_8259A top level on the board-level bus, standing in for the processor bus unit in system simulation and FPGA integration.

## Interface
- STROBE_CYCLES, 2, low time of each RD_n/WR_n/INTA_n pulse in CLK cycles (≥1)
- GAP_CYCLES, 1, all-strobes-high recovery time after each pulse (≥1)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset; asynchronous, active-high
- D  inout  8  PIC data bus; driven only during write transactions, else high-Z
- A0  out  1  PIC register select
- CS_n  out  1  PIC chip select, active low
- RD_n  out  1  read strobe, active low
- WR_n  out  1  write strobe, active low
- INTA_n  out  1  interrupt acknowledge strobe, active low
- INT  in  1  PIC interrupt request (asynchronous)
- int_en  in  1  enables automatic acknowledge of INT
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_a0  in  1  A0 value for the transaction
- cmd_data  in  8  write byte
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_data  out  8  read byte, held until next read
- vec_valid  out  1  one-cycle pulse, vector captured
- vec  out  16  captured vector, held until next acknowledge

## Operation
- INT passes through a 2-flop synchronizer (int_s).
- States: IDLE, SETUP, STROBE, HOLD, GAP, ACK_STROBE, ACK_GAP.
- cmd_ready = (state==IDLE) && !(int_en && int_s).
- IDLE: int_en && int_s → ACK_STROBE (acknowledge wins over simultaneous cmd_valid); else cmd_valid → latch cmd_write/cmd_a0/cmd_data → SETUP.
- SETUP (1 cycle): CS_n=0, A0=latched; D driven if write.
- STROBE (STROBE_CYCLES): WR_n or RD_n low; read samples D on the last STROBE edge.
- HOLD (1 cycle): strobes high, CS_n=0, A0 held, D still driven on write; rsp_valid=1 on read.
- GAP (GAP_CYCLES): CS_n=1, D released → IDLE.
- Acknowledge: NPULSE INTA_n pulses (2 by default), each STROBE_CYCLES low, separated by GAP_CYCLES in ACK_GAP; CS_n, RD_n and WR_n stay high; D never driven. Pulse counter 2 bits.
- Default: byte sampled on last cycle of pulse 2 → vec={8'h00,byte}; vec_valid in first ACK_GAP cycle after final pulse; then remaining gap → IDLE.
- INT deasserting mid-acknowledge does not abort the sequence.
- Reset values: CS_n=RD_n=WR_n=INTA_n=1, A0=0, D high-Z, rsp_valid=vec_valid=0, rsp_data=0, vec=0, state IDLE, cmd_ready=1.

## Timing
- Accept at edge 0: SETUP cycle 1, STROBE cycles 2..1+S, HOLD 2+S, GAP through 2+S+G; cmd_ready high at cycle 3+S+G. Transaction = 2+S+G cycles (5 at defaults).
- rsp_valid coincides with HOLD; rsp_data valid that cycle onward.
- Acknowledge (default) = 2S+2G cycles after leaving IDLE; INT-to-first-INTA_n latency 3 cycles (2 sync + IDLE decision).
- RST asserted anywhere: strobes/CS_n deassert and D releases immediately (async); in-flight command dropped, no rsp_valid/vec_valid.

## Configuration
- PIC_HOST_8085_EN defined: NPULSE=3 (8085 CALL sequence); byte 1 (opcode, expected 8'hCD) discarded, byte 2 → vec[7:0], byte 3 → vec[15:8].
- Undefined: NPULSE=2, 8086 mode as above; vec[15:8]=0.

## Structure
- Package pic_host_pkg: state encoding, NPULSE, CALL_OPCODE=8'hCD.
- Sub-module pic_host_sync: 2-flop INT synchronizer with async reset to 0.

## Test plan
- Write cmd_a0=0, cmd_data=0x13, S=2, G=1 → CS_n low cycles 1–4, WR_n low cycles 2–3, D=0x13 cycles 1–4 then Z, cmd_ready high at cycle 6.
- Read cmd_a0=1, PIC model drives 0x5A while RD_n low → one rsp_valid pulse in cycle 4, rsp_data=0x5A.
- INT=1, int_en=1, model returns 0x48 on pulse 2 → two 2-cycle INTA_n pulses separated by 1 high cycle, CS_n stays high, vec_valid once with vec=0x0048.
- INT rising and cmd_valid same cycle → acknowledge runs first, command accepted only after return to IDLE; int_en=0 → INT ignored, INTA_n stays high.
- RST pulsed during write STROBE → WR_n/CS_n high and D Z without waiting for CLK; after release cmd_ready=1, no rsp_valid.
- PIC_HOST_8085_EN, bytes 0xCD, 0x20, 0x10 → three INTA_n pulses, vec=0x1020.
